// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit pipeline: direct-mapped write-through,
// no-write-allocate data cache with a miss/write FSM that stalls upstream stages.
module mem_stage #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] pipeline_reg_in,
  input  logic [3:0]  opc_in,
  output logic [36:0] pipeline_reg_out,
  output logic [3:0]  opc_out,
  output logic        memory_stall,
  output logic [2:0]  mem_op_dest,
  output logic [15:0] mem_res,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_wdata,
  input  logic [15:0] ext_rdata,
  input  logic        ext_ack
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [15:0]        data_q [LINES];

  logic               ext_req_q, ext_req_d;
  logic               ext_we_q, ext_we_d;
  logic [15:0]        ext_addr_q, ext_addr_d;
  logic [15:0]        ext_wdata_q, ext_wdata_d;
  logic [15:0]        fill_q, fill_d;
  logic [15:0]        hold_alu_q, hold_alu_d;
  logic [4:0]         hold_wb_q, hold_wb_d;
  logic               hold_load_q, hold_load_d;
  logic [3:0]         hold_opc_q, hold_opc_d;
  logic [36:0]        out_q, out_d;
  logic [3:0]         opc_out_q, opc_out_d;

  logic [15:0]        addr_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic [INDEX_BITS-1:0] pend_idx_s;
  logic               store_s;
  logic               load_s;
  logic               hit_s;
  logic               pend_hit_s;
  logic               ack_s;
  logic               stall_s;
  logic               line_we_s;
  logic [15:0]        line_data_s;

  assign addr_s      = pipeline_reg_in[37:22];
  assign idx_s       = addr_s[INDEX_BITS-1:0];
  assign pend_idx_s  = ext_addr_q[INDEX_BITS-1:0];
  assign store_s     = pipeline_reg_in[21];
  assign load_s      = pipeline_reg_in[4] & pipeline_reg_in[0] & ~pipeline_reg_in[21];
  assign ack_s       = ext_ack & ext_req_q;

  // Tag compare for the live instruction and for the in-flight request.
  always_comb begin
    hit_s      = valid_q[idx_s] & (tag_q[idx_s] == addr_s[15:INDEX_BITS]);
    pend_hit_s = valid_q[pend_idx_s] & (tag_q[pend_idx_s] == ext_addr_q[15:INDEX_BITS]);
  end

  // Next-state, external request, cache update and output-register logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    fill_d      = fill_q;
    hold_alu_d  = hold_alu_q;
    hold_wb_d   = hold_wb_q;
    hold_load_d = hold_load_q;
    hold_opc_d  = hold_opc_q;
    out_d       = 37'd0;
    opc_out_d   = 4'd0;
    stall_s     = 1'b0;
    line_we_s   = 1'b0;
    line_data_s = ext_rdata;

    case (state_q)
      IDLE: begin
        if (store_s || (load_s && !hit_s)) begin
          stall_s     = 1'b1;
          ext_req_d   = 1'b1;
          ext_we_d    = store_s;
          ext_addr_d  = addr_s;
          hold_alu_d  = addr_s;
          hold_wb_d   = pipeline_reg_in[4:0];
          hold_load_d = load_s;
          hold_opc_d  = opc_in;
          if (store_s) begin
            ext_wdata_d = pipeline_reg_in[20:5];
            state_d     = WR_WAIT;
          end else begin
            ext_wdata_d = ext_wdata_q;
            state_d     = RD_WAIT;
          end
        end else begin
          out_d     = {(load_s ? data_q[idx_s] : 16'd0), addr_s, pipeline_reg_in[4:0]};
          opc_out_d = opc_in;
        end
      end
      RD_WAIT: begin
        stall_s = 1'b1;
        if (ack_s) begin
          fill_d              = ext_rdata;
          line_we_s           = 1'b1;
          line_data_s         = ext_rdata;
          valid_d[pend_idx_s] = 1'b1;
          ext_req_d           = 1'b0;
          state_d             = DONE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_WAIT: begin
        stall_s = 1'b1;
        if (ack_s) begin
          // Write-through: only refresh a line that already holds this address.
          if (pend_hit_s) begin
            line_we_s   = 1'b1;
            line_data_s = ext_wdata_q;
          end else begin
            line_we_s = 1'b0;
          end
          ext_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          state_d = WR_WAIT;
        end
      end
      DONE: begin
        out_d     = {(hold_load_q ? fill_q : 16'd0), hold_alu_q, hold_wb_q};
        opc_out_d = hold_opc_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, request outputs and pipeline output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 16'd0;
      ext_wdata_q <= 16'd0;
      fill_q      <= 16'd0;
      hold_alu_q  <= 16'd0;
      hold_wb_q   <= 5'd0;
      hold_load_q <= 1'b0;
      hold_opc_q  <= 4'd0;
      out_q       <= 37'd0;
      opc_out_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      fill_q      <= fill_d;
      hold_alu_q  <= hold_alu_d;
      hold_wb_q   <= hold_wb_d;
      hold_load_q <= hold_load_d;
      hold_opc_q  <= hold_opc_d;
      out_q       <= out_d;
      opc_out_q   <= opc_out_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_q[pend_idx_s]  <= ext_addr_q[15:INDEX_BITS];
      data_q[pend_idx_s] <= line_data_s;
    end
  end

  assign pipeline_reg_out = out_q;
  assign opc_out          = opc_out_q;
  assign memory_stall     = stall_s;
  assign mem_op_dest      = pipeline_reg_in[3:1];
  assign mem_res          = addr_s;
  assign ext_req          = ext_req_q;
  assign ext_we           = ext_we_q;
  assign ext_addr         = ext_addr_q;
  assign ext_wdata        = ext_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random instruction
// stream checked against an address-level cache/memory model.
module tb_mem_stage;

  localparam int LINES = 64;

  logic        clk;
  logic        rst;
  logic [37:0] pipeline_reg_in;
  logic [3:0]  opc_in;
  logic [36:0] pipeline_reg_out;
  logic [3:0]  opc_out;
  logic        memory_stall;
  logic [2:0]  mem_op_dest;
  logic [15:0] mem_res;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: backing memory and the address resident in each line.
  logic [15:0] mem_m [int];
  int          resident_m [int];

  mem_stage #(.INDEX_BITS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_reg_in  (pipeline_reg_in),
    .opc_in           (opc_in),
    .pipeline_reg_out (pipeline_reg_out),
    .opc_out          (opc_out),
    .memory_stall     (memory_stall),
    .mem_op_dest      (mem_op_dest),
    .mem_res          (mem_res),
    .ext_req          (ext_req),
    .ext_we           (ext_we),
    .ext_addr         (ext_addr),
    .ext_wdata        (ext_wdata),
    .ext_rdata        (ext_rdata),
    .ext_ack          (ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    if (!mem_m.exists(a)) mem_m[a] = 16'($urandom);
    return mem_m[a];
  endfunction

  // Runs one instruction from a negedge and returns at the negedge after its result is visible.
  task automatic exec(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                      input logic wb_en, input logic [2:0] dest, input logic mux,
                      input logic [3:0] opc, input int n_ack);
    logic        is_load;
    int          idx;
    logic        hit;
    logic        stall_e;
    logic [15:0] rd_e;
    is_load = wb_en & mux & ~we;
    idx     = int'(addr) % LINES;
    hit     = resident_m.exists(idx) && (resident_m[idx] == int'(addr));
    stall_e = we | (is_load & ~hit);
    pipeline_reg_in = {addr, we, wdata, wb_en, dest, mux};
    opc_in          = opc;
    #1;
    check_eq("stall_first", memory_stall, stall_e);
    check_eq("mem_res", mem_res, addr);
    check_eq("mem_op_dest", mem_op_dest, dest);
    if (!stall_e) begin
      rd_e = is_load ? mem_rd(int'(addr)) : 16'd0;
      @(negedge clk);
      check_eq("out_fast", pipeline_reg_out, {rd_e, addr, wb_en, dest, mux});
      check_eq("opc_fast", opc_out, opc);
    end else begin
      @(negedge clk);
      check_eq("ext_req_on", ext_req, 1'b1);
      check_eq("ext_we", ext_we, we);
      check_eq("ext_addr", ext_addr, addr);
      if (we) check_eq("ext_wdata", ext_wdata, wdata);
      check_eq("bubble_out", {opc_out, pipeline_reg_out}, 41'd0);
      for (int k = 1; k <= n_ack; k++) begin
        if (k > 1) @(negedge clk);
        check_eq("stall_wait", memory_stall, 1'b1);
        check_eq("ext_req_hold", {ext_req, ext_we, ext_addr}, {1'b1, we, addr});
        ext_rdata = 16'($urandom);
        if (k == n_ack) begin
          ext_ack = 1'b1;
          if (!we) ext_rdata = mem_rd(int'(addr));
        end
      end
      @(negedge clk);
      ext_ack = 1'b0;
      check_eq("ext_req_off", ext_req, 1'b0);
      check_eq("stall_done", memory_stall, 1'b0);
      check_eq("bubble_wait", {opc_out, pipeline_reg_out}, 41'd0);
      if (we) begin
        mem_m[int'(addr)] = wdata;
        rd_e = 16'd0;
      end else begin
        resident_m[idx] = int'(addr);
        rd_e = mem_rd(int'(addr));
      end
      @(negedge clk);
      check_eq("out_done", pipeline_reg_out, {rd_e, addr, wb_en, dest, mux});
      check_eq("opc_done", opc_out, opc);
    end
  endtask

  task automatic do_load(input logic [15:0] addr, input int n_ack);
    exec(addr, 1'b0, 16'($urandom), 1'b1, 3'($urandom), 1'b1, 4'($urandom), n_ack);
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data, input int n_ack);
    exec(addr, 1'b1, data, 1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), n_ack);
  endtask

  initial begin
    logic [15:0] a;
    int          r;
    rst             = 1'b0;
    pipeline_reg_in = 38'd0;
    opc_in          = 4'd0;
    ext_rdata       = 16'd0;
    ext_ack         = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out", {opc_out, pipeline_reg_out}, 41'd0);
    check_eq("rst_ext", {ext_req, ext_we, ext_addr, ext_wdata}, 34'd0);
    rst = 1'b1;
    @(negedge clk);

    // Load miss with a 3-cycle ack, then the same load hits.
    mem_m[16'h0010] = 16'hBEEF;
    exec(16'h0010, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b1, 4'h8, 3);
    exec(16'h0010, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 4'h9, 1);

    // Store hit then load of the new data; store miss does not allocate.
    do_store(16'h0010, 16'h1234, 1);
    do_load(16'h0010, 1);
    do_store(16'h0050, 16'h5555, 2);
    do_load(16'h0050, 2);
    do_load(16'h0010, 1);

    // Pass-through ALU op with a spurious ack while idle.
    ext_ack   = 1'b1;
    ext_rdata = 16'hDEAD;
    exec(16'h0007, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 4'h3, 1);
    ext_ack   = 1'b0;
    do_load(16'h0010, 1);

    // Reset in the middle of a read wait abandons the request.
    pipeline_reg_in = {16'h0090, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1};
    opc_in          = 4'h2;
    @(negedge clk);
    check_eq("pre_rst_req", ext_req, 1'b1);
    rst             = 1'b0;
    pipeline_reg_in = 38'd0;
    opc_in          = 4'd0;
    #1;
    check_eq("mid_rst_ext", {ext_req, ext_we, ext_addr, ext_wdata}, 34'd0);
    check_eq("mid_rst_out", {opc_out, pipeline_reg_out}, 41'd0);
    resident_m.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_stall", memory_stall, 1'b0);
    do_load(16'h0010, 2);
    do_load(16'h0010, 1);

    // Random instruction stream over a few conflicting addresses.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'h0010;
        1:       a = 16'h0050;
        2:       a = {10'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
        default: a = 16'($urandom);
      endcase
      r = int'($urandom_range(0, 3));
      case (r)
        0:       do_load(a, int'($urandom_range(1, 4)));
        1:       do_store(a, 16'($urandom), int'($urandom_range(1, 4)));
        2:       exec(a, 1'b0, 16'($urandom), 1'b1, 3'($urandom), 1'b0, 4'($urandom), 1);
        default: exec(a, 1'b0, 16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                      4'($urandom), int'($urandom_range(1, 4)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
